// File: rtl/rx_fifo_param_if.sv
// Handshake bundle between the receive FIFO and its neighbours.
//   master : writer/reader side (drives requests and write data)
//   slave  : FIFO side (drives head data, occupancy and flags)
// Ports carried:
//   flush, clear_err, w_enable, w_data, r_enable      master -> slave
//   r_data, empty, full, almost_empty, almost_full,
//   count, overflow_err, underflow_err                slave  -> master
interface rx_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  clear_err;
  logic                  w_enable;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_enable;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output flush, clear_err, w_enable, w_data, r_enable,
    input  r_data, empty, full, almost_empty, almost_full, count,
           overflow_err, underflow_err
  );

  modport slave (
    input  flush, clear_err, w_enable, w_data, r_enable,
    output r_data, empty, full, almost_empty, almost_full, count,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/rx_fifo_param.sv
// Parametrised single-clock receive FIFO with first-word-fall-through head,
// occupancy count, almost-full/almost-empty flags, synchronous flush and
// sticky overflow/underflow error flags.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   n_rst : synchronous active-low reset (highest priority)
//   bus   : rx_fifo_param_if.slave (requests in, data/flags out)
module rx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input logic          clk,
  input logic          n_rst,
  rx_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("rx_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("rx_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  empty_q;
  logic                  full_q;
  logic                  ae_q;
  logic                  af_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  do_wr;
  logic                  do_rd;
  logic                  ovf_evt;
  logic                  unf_evt;

  // A write into a full FIFO is accepted only when a read frees a slot
  // in the same edge.
  assign do_wr   = bus.w_enable & (~full_q | bus.r_enable);
  assign do_rd   = bus.r_enable & ~empty_q;
  assign cnt_nxt = cnt + CW'(do_wr) - CW'(do_rd);

  // Requests in a flush cycle are ignored, so they raise no errors either.
  assign ovf_evt = ~bus.flush & bus.w_enable & full_q & ~bus.r_enable;
  assign unf_evt = ~bus.flush & bus.r_enable & empty_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wptr    <= '0;
        rptr    <= '0;
        cnt     <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        ae_q    <= 1'b1;
        af_q    <= 1'b0;
      end else begin
        if (do_wr) wptr <= wptr + 1'b1;
        if (do_rd) rptr <= rptr + 1'b1;
        cnt     <= cnt_nxt;
        empty_q <= (cnt_nxt == '0);
        full_q  <= (cnt_nxt == CW'(DEPTH));
        ae_q    <= (cnt_nxt <= CW'(AE_LEVEL));
        af_q    <= (cnt_nxt >= CW'(AF_LEVEL));
      end
      // A new error event outranks clear_err in the same cycle.
      ovf_q <= (ovf_q & ~bus.clear_err) | ovf_evt;
      unf_q <= (unf_q & ~bus.clear_err) | unf_evt;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (n_rst && !bus.flush && do_wr) mem[wptr] <= bus.w_data;
  end

  assign bus.r_data        = empty_q ? '0 : mem[rptr];
  assign bus.empty         = empty_q;
  assign bus.full          = full_q;
  assign bus.almost_empty  = ae_q;
  assign bus.almost_full   = af_q;
  assign bus.count         = cnt;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_rx_fifo_param.sv
module tb_rx_fifo_param;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf;

  rx_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(DEPTH)) bus();

  rx_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  // One clock edge with the given inputs; the queue model advances with it.
  task automatic cyc(input bit fl, input bit ce, input bit we,
                     input logic [7:0] wd, input bit re);
    int  sz;
    bit  wr_ok, rd_ok;
    bus.flush = fl; bus.clear_err = ce; bus.w_enable = we;
    bus.w_data = wd; bus.r_enable = re;
    @(posedge clk); #1;
    sz = q.size();
    if (ce) begin m_ovf = 0; m_unf = 0; end
    if (fl) q.delete();
    else begin
      if (we && sz == DEPTH && !re) m_ovf = 1;
      if (re && sz == 0) m_unf = 1;
      rd_ok = re && sz > 0;
      wr_ok = we && (sz < DEPTH || re);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(wd);
    end
    bus.flush = 0; bus.clear_err = 0; bus.w_enable = 0; bus.r_enable = 0;
  endtask

  task automatic do_reset();
    n_rst = 0;
    bus.w_enable = 1; bus.w_data = 8'hEE; bus.r_enable = 1;
    bus.flush = 0; bus.clear_err = 0;
    @(posedge clk); #1;
    q.delete(); m_ovf = 0; m_unf = 0;
    n_rst = 1;
    bus.w_enable = 0; bus.r_enable = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
         bus.overflow_err, bus.underflow_err, bus.r_data} !== {4'd0, 6'b101000, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b unf=%b rd=%h, want 0 1 0 1 0 0 0 00",
               bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
               bus.overflow_err, bus.underflow_err, bus.r_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 8'hA1 + 8'(i), 0);
      if (i == 0) begin
        vectors++;
        if (bus.empty !== 1'b0 || bus.r_data !== 8'hA1) begin
          errors++;
          $display("FAIL fill_first: empty=%b r_data=%h, want 0 a1", bus.empty, bus.r_data);
        end
      end
      if (i == 4 || i == 5) begin
        vectors++;
        if (bus.almost_full !== (i == 5)) begin
          errors++;
          $display("FAIL fill_af: after %0d writes almost_full=%b, want %b", i + 1, bus.almost_full, i == 5);
        end
      end
    end
    vectors++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d, want 1 8", bus.full, bus.count);
    end
    cyc(0, 0, 1, 8'hFF, 0);
    vectors++;
    if (bus.overflow_err !== 1'b1 || bus.count !== 4'd8 || bus.r_data !== 8'hA1) begin
      errors++;
      $display("FAIL fill_overflow: ovf=%b count=%0d r_data=%h, want 1 8 a1",
               bus.overflow_err, bus.count, bus.r_data);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bus.r_data !== 8'hA1 + 8'(i)) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h, want %h", i, bus.r_data, 8'hA1 + 8'(i));
      end
      cyc(0, 0, 0, 8'h00, 1);
      if (i == 5 || i == 6) begin
        vectors++;
        if (bus.almost_empty !== (i == 6)) begin
          errors++;
          $display("FAIL drain_ae: after %0d reads almost_empty=%b, want %b", i + 1, bus.almost_empty, i == 6);
        end
      end
    end
    vectors++;
    if (bus.empty !== 1'b1 || bus.r_data !== 8'h00) begin
      errors++;
      $display("FAIL drain_empty: empty=%b r_data=%h, want 1 00", bus.empty, bus.r_data);
    end
    cyc(0, 0, 0, 8'h00, 1);
    vectors++;
    if (bus.underflow_err !== 1'b1 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL drain_underflow: unf=%b count=%0d, want 1 0", bus.underflow_err, bus.count);
    end
    cyc(0, 1, 0, 8'h00, 0);
    vectors++;
    if (bus.underflow_err !== 1'b0 || bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: ovf=%b unf=%b, want 0 0", bus.overflow_err, bus.underflow_err);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'($urandom), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'h10 + 8'(i), 0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.r_data !== 8'h10 + 8'(i) || bus.count !== 4'(6 - i)) begin
        errors++;
        $display("FAIL wrap[%0d]: r_data=%h count=%0d, want %h %0d",
                 i, bus.r_data, bus.count, 8'h10 + 8'(i), 6 - i);
      end
      cyc(0, 0, 0, 8'h00, 1);
    end
    vectors++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: count=%0d empty=%b, want 0 1", bus.count, bus.empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h60 + 8'(i), 0);
    cyc(0, 0, 1, 8'h55, 1);
    vectors++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow_err !== 1'b0 || bus.r_data !== 8'h61) begin
      errors++;
      $display("FAIL rw_full: count=%0d full=%b ovf=%b r_data=%h, want 8 1 0 61",
               bus.count, bus.full, bus.overflow_err, bus.r_data);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'h55 : 8'h61 + 8'(i);
      vectors++;
      if (bus.r_data !== exp) begin
        errors++;
        $display("FAIL rw_full_order[%0d]: got %h, want %h", i, bus.r_data, exp);
      end
      cyc(0, 0, 0, 8'h00, 1);
    end
    cyc(0, 0, 1, 8'h33, 1);
    vectors++;
    if (bus.count !== 4'd1 || bus.r_data !== 8'h33 || bus.underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL rw_empty: count=%0d r_data=%h unf=%b, want 1 33 1",
               bus.count, bus.r_data, bus.underflow_err);
    end
    cyc(0, 1, 0, 8'h00, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'h80 + 8'(i), 0);
    cyc(0, 0, 1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1);
    vectors++;
    if (bus.count !== 4'd4 || bus.overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: count=%0d ovf=%b, want 4 1", bus.count, bus.overflow_err);
    end
    cyc(1, 0, 1, 8'hEE, 0);
    vectors++;
    if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
         bus.overflow_err, bus.underflow_err} !== {4'd0, 6'b110010}) begin
      errors++;
      $display("FAIL flush_state: cnt=%0d e=%b ae=%b f=%b af=%b ovf=%b unf=%b, want 0 1 1 0 0 1 0",
               bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
               bus.overflow_err, bus.underflow_err);
    end
    cyc(0, 0, 1, 8'h12, 0);
    vectors++;
    if (bus.count !== 4'd1 || bus.r_data !== 8'h12) begin
      errors++;
      $display("FAIL flush_discard: count=%0d r_data=%h, want 1 12", bus.count, bus.r_data);
    end
  endtask

  task automatic test_midreset();
    cyc(0, 0, 1, 8'h21, 0);
    cyc(0, 0, 1, 8'h22, 0);
    vectors++;
    if (bus.count !== 4'd3) begin
      errors++;
      $display("FAIL midreset_setup: count=%0d, want 3", bus.count);
    end
    do_reset();
    vectors++;
    if ({bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
         bus.overflow_err, bus.underflow_err, bus.r_data} !== {4'd0, 6'b101000, 8'h00}) begin
      errors++;
      $display("FAIL midreset_state: cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b unf=%b rd=%h, want 0 1 0 1 0 0 0 00",
               bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
               bus.overflow_err, bus.underflow_err, bus.r_data);
    end
    cyc(0, 0, 1, 8'h77, 0);
    vectors++;
    if (bus.r_data !== 8'h77 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL midreset_write: r_data=%h count=%0d, want 77 1", bus.r_data, bus.count);
    end
  endtask

  task automatic test_random();
    logic [7:0] e_rd;
    int         sz;
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 99) < ((n / 100) % 2 ? 70 : 40), 8'($urandom),
          $urandom_range(0, 99) < ((n / 100) % 2 ? 40 : 70));
      sz   = q.size();
      e_rd = (sz > 0) ? q[0] : 8'h00;
      vectors++;
      if ({bus.r_data, bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
           bus.overflow_err, bus.underflow_err} !==
          {e_rd, 4'(sz), sz == 0, sz == DEPTH, sz <= AE, sz >= AF, m_ovf, m_unf}) begin
        errors++;
        $display("FAIL random[%0d]: rd=%h cnt=%0d e/f/ae/af/ovf/unf=%b%b%b%b%b%b, want rd=%h cnt=%0d %b%b%b%b%b%b",
                 n, bus.r_data, bus.count, bus.empty, bus.full, bus.almost_empty,
                 bus.almost_full, bus.overflow_err, bus.underflow_err,
                 e_rd, sz, sz == 0, sz == DEPTH, sz <= AE, sz >= AF, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    bus.flush = 0; bus.clear_err = 0; bus.w_enable = 0;
    bus.w_data = 0; bus.r_enable = 0;
    m_ovf = 0; m_unf = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
